// File: rtl/pfs_detect_accum.sv
// Fault-detection accumulator for the bit-parallel CUT evaluator: collects a sticky mask of
// faulty machines whose output differs from the good machine, with fault dropping.
module pfs_detect_accum #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4,
   parameter int PAT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] active_mask,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             good_out,
   input  logic [WIDTH-1:0] fault_out,
   input  logic             pat_last,
   output logic [WIDTH-1:0] det_mask,
   output logic [CNT_W-1:0] det_count,
   output logic [PAT_W-1:0] pat_count,
   output logic             all_det,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_COUNT, S_DONE} state_t;

   state_t           r_state;
   state_t           w_nxt_state;
   logic [WIDTH-1:0] r_act_mask;
   logic [WIDTH-1:0] r_det_mask;
   logic [CNT_W-1:0] r_det_count;
   logic [PAT_W-1:0] r_pat_count;
   logic             r_all_det;

   logic             w_accept;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_nxt_mask;
   logic             w_drop;

   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] m);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(m[i]);
      return c;
   endfunction

   // Pattern counter holds at all-ones rather than wrapping.
   function automatic logic [PAT_W-1:0] sat_inc(input logic [PAT_W-1:0] v);
      return (&v) ? v : v + PAT_W'(1);
   endfunction

   assign w_accept   = in_valid && (r_state == S_RUN);
   assign w_diff     = (fault_out ^ {WIDTH{good_out}}) & r_act_mask;
   assign w_nxt_mask = r_det_mask | w_diff;
   assign w_drop     = (w_nxt_mask == r_act_mask);

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nxt_state = S_RUN;
         S_RUN:   if (w_accept && (w_drop || pat_last)) w_nxt_state = S_COUNT;
         S_COUNT: w_nxt_state = S_DONE;
         S_DONE:  w_nxt_state = S_IDLE;
         default: w_nxt_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_act_mask  <= '0;
         r_det_mask  <= '0;
         r_det_count <= '0;
         r_pat_count <= '0;
         r_all_det   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         if (r_state == S_IDLE && start) begin
            r_act_mask  <= active_mask;
            r_det_mask  <= '0;
            r_det_count <= '0;
            r_pat_count <= '0;
            r_all_det   <= 1'b0;
         end
         if (w_accept) begin
            r_det_mask  <= w_nxt_mask;
            r_pat_count <= sat_inc(r_pat_count);
            if (w_drop) r_all_det <= 1'b1;
         end
         // Count is taken from the settled mask so it is stable by the time done fires.
         if (r_state == S_COUNT) r_det_count <= popcount(r_det_mask);
      end
   end

   assign in_ready  = (r_state == S_RUN);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign det_mask  = r_det_mask;
   assign det_count = r_det_count;
   assign pat_count = r_pat_count;
   assign all_det   = r_all_det;

endmodule
